// File: rtl/cluster_collector.sv
// Collects per-pass clusters from each partition priority encoder and snapshots them
// into one globally addressed, frame-consistent bus on encoder 0's final pass.
module cluster_collector #(
  parameter int NUM_ENCODERS         = 2,
  parameter int CLUSTERS_PER_ENCODER = 4,
  parameter int ENC_WIDTH            = 768,
  parameter int MXADRBITS            = 11,
  parameter int MXCNTBITS            = 3,
  parameter int OUTPUT_LATCH         = 0
) (
  input  logic                                                   clock,
  input  logic                                                   reset,
  input  logic                                                   latch_pulse,
  input  logic [NUM_ENCODERS*$clog2(CLUSTERS_PER_ENCODER)-1:0]   pass_in,
  input  logic [NUM_ENCODERS*MXADRBITS-1:0]                      enc_adr,
  input  logic [NUM_ENCODERS*MXCNTBITS-1:0]                      enc_cnt,
  input  logic [NUM_ENCODERS-1:0]                                enc_vpf,
  input  logic [NUM_ENCODERS-1:0]                                enc_more,
  output logic [NUM_ENCODERS*CLUSTERS_PER_ENCODER*MXADRBITS-1:0] adr_out,
  output logic [NUM_ENCODERS*CLUSTERS_PER_ENCODER*MXCNTBITS-1:0] cnt_out,
  output logic [NUM_ENCODERS*CLUSTERS_PER_ENCODER-1:0]           vpf_out,
  output logic                                                   latch_out,
  output logic                                                   overflow,
  output logic                                                   sync_err
);
  // state     | meaning
  // S_WAIT    | after reset or a snapshot; waiting for encoder 0 to start a frame (pass 0)
  // S_COLLECT | frame in progress; encoder 0's last pass triggers the snapshot

  localparam int NE  = NUM_ENCODERS;
  localparam int CPE = CLUSTERS_PER_ENCODER;
  localparam int PB  = $clog2(CPE);
  localparam int NS  = NE * CPE;
  localparam int AW  = MXADRBITS;
  localparam int CW  = MXCNTBITS;
  localparam logic [PB-1:0] LAST = PB'(CPE - 1);

  if (NE < 1 || CPE < 2 || NE * ENC_WIDTH > 2 ** AW) begin : g_param_err
    $error("cluster_collector: bad parameters (NE>=1, CPE>=2, NE*ENC_WIDTH<=2**MXADRBITS)");
  end

  typedef enum logic {S_WAIT = 1'b0, S_COLLECT = 1'b1} state_t;
  state_t state_q, state_d;

  logic [PB-1:0] pass0;
  logic          snap;
  assign pass0 = pass_in[PB-1:0];

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_WAIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:    if (pass0 == '0)  state_d = S_COLLECT;
      S_COLLECT: if (pass0 == LAST) state_d = S_WAIT;
      default:   state_d = S_WAIT;
    endcase
  end

  always_comb begin
    snap = 1'b0;
    if (state_q == S_COLLECT && pass0 == LAST) snap = 1'b1;
  end

  // The last pass is never stored: it is taken live at snapshot time.
  logic [AW-1:0] slot_adr [NE][CPE-1];
  logic [CW-1:0] slot_cnt [NE][CPE-1];
  logic          slot_vpf [NE][CPE-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < NE; e++) begin
        for (int i = 0; i < CPE - 1; i++) begin
          slot_adr[e][i] <= '0;
          slot_cnt[e][i] <= '0;
          slot_vpf[e][i] <= 1'b0;
        end
      end
    end else begin
      for (int e = 0; e < NE; e++) begin
        for (int i = 0; i < CPE - 1; i++) begin
          if (pass_in[e*PB +: PB] == PB'(i)) begin
            slot_adr[e][i] <= enc_adr[e*AW +: AW];
            slot_cnt[e][i] <= enc_cnt[e*CW +: CW];
            slot_vpf[e][i] <= enc_vpf[e];
          end else if (latch_pulse) begin
            slot_vpf[e][i] <= 1'b0;
          end
        end
      end
    end
  end

  logic [NS*AW-1:0] adr_g;
  logic [NS*CW-1:0] cnt_g;
  logic [NS-1:0]    vpf_g;
  logic [NE-1:0]    pass_bad;
  logic             ovf_c, sync_c;

  for (genvar e = 0; e < NE; e++) begin : g_enc
    localparam logic [AW-1:0] OFS = AW'(e * ENC_WIDTH);
    assign pass_bad[e] = (pass_in[e*PB +: PB] != LAST);
    for (genvar i = 0; i < CPE; i++) begin : g_slot
      localparam int K = e * CPE + i;
      logic          v;
      logic [AW-1:0] a;
      logic [CW-1:0] c;
      if (i < CPE - 1) begin : g_reg
        assign v = slot_vpf[e][i];
        assign a = slot_adr[e][i];
        assign c = slot_cnt[e][i];
      end else begin : g_live
        assign v = enc_vpf[e];
        assign a = enc_adr[e*AW +: AW];
        assign c = enc_cnt[e*CW +: CW];
      end
      assign vpf_g[K]          = v;
      assign adr_g[K*AW +: AW] = v ? a + OFS : '0;
      assign cnt_g[K*CW +: CW] = v ? c : '0;
    end
  end

  assign ovf_c  = |(enc_more & enc_vpf);
  assign sync_c = |pass_bad;

  logic [NS*AW-1:0] adr_s1;
  logic [NS*CW-1:0] cnt_s1;
  logic [NS-1:0]    vpf_s1;
  logic             latch_s1, ovf_s1, sync_s1;

  always_ff @(posedge clock) begin
    if (reset) begin
      adr_s1   <= '0;
      cnt_s1   <= '0;
      vpf_s1   <= '0;
      latch_s1 <= 1'b0;
      ovf_s1   <= 1'b0;
      sync_s1  <= 1'b0;
    end else begin
      latch_s1 <= snap;
      ovf_s1   <= snap & ovf_c;
      sync_s1  <= snap & sync_c;
      if (snap) begin
        adr_s1 <= adr_g;
        cnt_s1 <= cnt_g;
        vpf_s1 <= vpf_g;
      end
    end
  end

  if (OUTPUT_LATCH != 0) begin : g_olatch
    logic [NS*AW-1:0] adr_s2;
    logic [NS*CW-1:0] cnt_s2;
    logic [NS-1:0]    vpf_s2;
    logic             latch_s2, ovf_s2, sync_s2;

    always_ff @(posedge clock) begin
      if (reset) begin
        adr_s2   <= '0;
        cnt_s2   <= '0;
        vpf_s2   <= '0;
        latch_s2 <= 1'b0;
        ovf_s2   <= 1'b0;
        sync_s2  <= 1'b0;
      end else begin
        latch_s2 <= latch_s1;
        ovf_s2   <= ovf_s1;
        sync_s2  <= sync_s1;
        if (latch_s1) begin
          adr_s2 <= adr_s1;
          cnt_s2 <= cnt_s1;
          vpf_s2 <= vpf_s1;
        end
      end
    end

    assign adr_out   = adr_s2;
    assign cnt_out   = cnt_s2;
    assign vpf_out   = vpf_s2;
    assign latch_out = latch_s2;
    assign overflow  = ovf_s2;
    assign sync_err  = sync_s2;
  end else begin : g_direct
    assign adr_out   = adr_s1;
    assign cnt_out   = cnt_s1;
    assign vpf_out   = vpf_s1;
    assign latch_out = latch_s1;
    assign overflow  = ovf_s1;
    assign sync_err  = sync_s1;
  end

endmodule
